// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch front end: issues sequential word reads, queues returned words with their PCs.
// Optional FETCH_ALIGN_FAULT_EN: a misaligned redirect latches `fault` and stalls fetch until an aligned redirect.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        read,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] agent_to_host,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic [31:0] ins_pc,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   q_word  [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   tag_mem [DEPTH];
    logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
    logic [CW-1:0] count, outstanding, discard;

    logic          accept, hold, push, pop, can_issue, fault_n;
    logic [CW-1:0] count_n, out_n, discard_n;
    logic [OW-1:0] occ_n;
    logic [31:0]   target_pc, pc_base;

`ifdef FETCH_ALIGN_FAULT_EN
    logic fault_q;
    assign target_pc = redirect_pc;
    assign fault     = fault_q;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign target_pc     = {redirect_pc[31:2], 2'b00};
    assign fault         = 1'b0;
`endif

    assign byteenable = 4'b1111;
    assign ins_valid  = (count != '0) && !redirect && !fault;
    assign ins_word   = q_word[q_rd];
    assign ins_pc     = q_pc[q_rd];

    always_comb begin
        accept  = read && !waitrequest;
        hold    = read && waitrequest;
        pop     = ins_valid && ins_ready;
        push    = readdatavalid && (discard == '0) && !redirect;
        out_n   = outstanding + CW'(accept) - CW'(readdatavalid);
        count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
        // A request stuck in waitrequest at redirect time will still be answered, so it is owed a drop too.
        discard_n = redirect ? out_n + CW'(hold)
                             : discard - CW'(readdatavalid && (discard != '0));
        pc_base = redirect ? target_pc : fetch_pc;
`ifdef FETCH_ALIGN_FAULT_EN
        fault_n = redirect ? (redirect_pc[1:0] != 2'b00) : fault_q;
`else
        fault_n = 1'b0;
`endif
        occ_n     = {1'b0, count_n} + {1'b0, out_n};
        can_issue = (occ_n < OW'(DEPTH)) && !fault_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read        <= 1'b0;
            address     <= RESET_PC;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
`ifdef FETCH_ALIGN_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            count       <= count_n;
            outstanding <= out_n;
            discard     <= discard_n;
`ifdef FETCH_ALIGN_FAULT_EN
            fault_q     <= fault_n;
`endif
            if (accept)
                tag_wr <= tag_wr + AW'(1);
            if (readdatavalid)
                tag_rd <= tag_rd + AW'(1);

            if (redirect) begin
                q_rd <= '0;
                q_wr <= '0;
            end else begin
                if (push)
                    q_wr <= q_wr + AW'(1);
                if (pop)
                    q_rd <= q_rd + AW'(1);
            end

            // fetch_pc is the next address to present; a held request keeps read/address untouched.
            if (hold) begin
                fetch_pc <= pc_base;
            end else if (can_issue) begin
                read     <= 1'b1;
                address  <= pc_base;
                fetch_pc <= pc_base + 32'd4;
            end else begin
                read     <= 1'b0;
                address  <= pc_base;
                fetch_pc <= pc_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept)
            tag_mem[tag_wr] <= address;
        if (push) begin
            q_word[q_wr] <= agent_to_host;
            q_pc[q_wr]   <= tag_mem[tag_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            assert (count != CW'(DEPTH));
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model returns word = address with configurable latency and waitrequest stalls.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        read, waitrequest, readdatavalid;
    logic [31:0] address, agent_to_host;
    logic [3:0]  byteenable;
    logic        redirect, ins_valid, ins_ready, fault;
    logic [31:0] redirect_pc, ins_word, ins_pc;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .read(read), .address(address), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid), .agent_to_host(agent_to_host),
        .redirect(redirect), .redirect_pc(redirect_pc), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_word(ins_word), .ins_pc(ins_pc), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; int cyc; } del_t;
    typedef struct { logic [31:0] target; int lat; logic [31:0] e0, e1, e2, e3; } vec_t;

    rsp_t        pend[$];
    del_t        deliv[$];
    logic [31:0] acc_log[$];
    int          acc_cnt = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] wait_addr = 32'h8;
    int          wait_len = 0;
    int          wait_seen = 0;
    int          del_rd = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (readdatavalid && pend.size() > 0)
                pend.delete(0);
            if (read && !waitrequest) begin
                pend.push_back('{address, cyc + lat});
                acc_log.push_back(address);
                acc_cnt++;
            end
            if (ins_valid && ins_ready)
                deliv.push_back('{ins_pc, ins_word, cyc});
        end
        cyc++;
    end

    always @(negedge clk) begin
        waitrequest = 1'b0;
        if (!rst && read && address == wait_addr && wait_seen < wait_len) begin
            waitrequest = 1'b1;
            wait_seen++;
        end
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            readdatavalid = 1'b1;
            agent_to_host = pend[0].addr;
        end else begin
            readdatavalid = 1'b0;
            agent_to_host = 32'h0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        ins_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic next_deliv(input string name, output logic [31:0] pc, output logic [31:0] word,
                              output int dcyc);
        for (int i = 0; i < 200 && del_rd >= deliv.size(); i++)
            step();
        if (del_rd >= deliv.size()) begin
            total++;
            bad++;
            $display("FAIL %s: no delivery within 200 cycles", name);
            pc = 32'hDEAD_BEEF;
            word = 32'hDEAD_BEEF;
            dcyc = -1;
        end else begin
            pc = deliv[del_rd].pc;
            word = deliv[del_rd].word;
            dcyc = deliv[del_rd].cyc;
            del_rd++;
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        del_rd = deliv.size();
        step();
        redirect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[4];
        logic [31:0] pc, word;
        int          dc, prev_dc, a0, wcnt;

        vecs[0] = '{32'h0000_1000, 1, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        vecs[1] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vecs[2] = '{32'h0000_0080, 3, 32'h0000_0080, 32'h0000_0084, 32'h0000_0088, 32'h0000_008C};
        vecs[3] = '{32'h0000_7FFC, 2, 32'h0000_7FFC, 32'h0000_8000, 32'h0000_8004, 32'h0000_8008};

        // reset state
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b0;
        repeat (3) step();
        check("rst_read", {31'b0, read}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("byteenable", {28'b0, byteenable}, 32'hF);

        // streaming, word == address, one per cycle
        do_reset();
        lat = 1;
        ins_ready = 1'b1;
        step();
        check("read_after_rst", {31'b0, read}, 32'h1);
        prev_dc = 0;
        for (int i = 0; i < 8; i++) begin
            next_deliv("stream", pc, word, dc);
            check("stream_pc", pc, 32'(4 * i));
            check("stream_word", word, 32'(4 * i));
            if (i > 0)
                check("stream_rate", 32'(dc - prev_dc), 32'd1);
            prev_dc = dc;
        end

        // decoder stalled: exactly DEPTH reads accepted
        do_reset();
        ins_ready = 1'b0;
        a0 = acc_cnt;
        repeat (12) step();
        check("stall_accepts", 32'(acc_cnt - a0), 32'd4);
        check("stall_read_low", {31'b0, read}, 32'h0);
        check("stall_valid", {31'b0, ins_valid}, 32'h1);
        ins_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_deliv("stall_drain", pc, word, dc);
            check("stall_drain_pc", pc, 32'(4 * i));
        end

        // redirect vector table (streaming continues)
        foreach (vecs[k]) begin
            lat = vecs[k].lat;
            step();
            pulse_redirect(vecs[k].target);
            next_deliv("vec_e0", pc, word, dc);
            check("vec_pc0", pc, vecs[k].e0);
            check("vec_word0", word, vecs[k].e0);
            next_deliv("vec_e1", pc, word, dc);
            check("vec_pc1", pc, vecs[k].e1);
            next_deliv("vec_e2", pc, word, dc);
            check("vec_pc2", pc, vecs[k].e2);
            next_deliv("vec_e3", pc, word, dc);
            check("vec_pc3", pc, vecs[k].e3);
        end

        // 3-cycle latency, 4 reads in flight, redirect to 0x100
        do_reset();
        lat = 3;
        ins_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 50 && acc_cnt - a0 < 4; i++)
            step();
        check("lat3_inflight", 32'(acc_cnt - a0), 32'd4);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        del_rd = deliv.size();
        #1;
        check("lat3_valid_in_redirect", {31'b0, ins_valid}, 32'h0);
        step();
        redirect = 1'b0;
        ins_ready = 1'b1;
        next_deliv("lat3_first", pc, word, dc);
        check("lat3_first_pc", pc, 32'h100);
        check("lat3_first_word", word, 32'h100);
        next_deliv("lat3_second", pc, word, dc);
        check("lat3_second_pc", pc, 32'h104);

        // waitrequest held 5 cycles on address 8, redirect to 0x40 on the second
        do_reset();
        lat = 1;
        ins_ready = 1'b1;
        wait_addr = 32'h8;
        wait_len = 5;
        a0 = acc_log.size();
        del_rd = deliv.size();
        wcnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (waitrequest) begin
                wcnt++;
                check("wait_read_held", {31'b0, read}, 32'h1);
                check("wait_addr_held", address, 32'h8);
                redirect = (wcnt == 2);
                redirect_pc = 32'h40;
            end else begin
                redirect = 1'b0;
                if (wcnt >= 5) break;
            end
        end
        check("wait_cycles", 32'(wcnt), 32'd5);
        for (int i = 0; i < 20 && acc_log.size() < a0 + 4; i++)
            step();
        if (acc_log.size() >= a0 + 4) begin
            check("wait_acc_stale", acc_log[a0 + 2], 32'h8);
            check("wait_acc_next", acc_log[a0 + 3], 32'h40);
        end else begin
            check("wait_acc_count", 32'(acc_log.size() - a0), 32'd4);
        end
        next_deliv("wait_d0", pc, word, dc);
        check("wait_d0_pc", pc, 32'h0);
        next_deliv("wait_d1", pc, word, dc);
        check("wait_d1_pc", pc, 32'h40);
        check("wait_d1_word", word, 32'h40);

        // redirect coinciding with a response and a ready decoder
        for (int i = 0; i < 50 && !(readdatavalid && ins_valid); i++)
            step();
        check("coincide_found", {31'b0, readdatavalid && ins_valid}, 32'h1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        del_rd = deliv.size();
        #1;
        check("coincide_valid", {31'b0, ins_valid}, 32'h0);
        step();
        redirect = 1'b0;
        next_deliv("coincide_next", pc, word, dc);
        check("coincide_pc", pc, 32'h300);
        check("coincide_word", word, 32'h300);

        // misaligned redirect
        step();
        pulse_redirect(32'h102);
`ifdef FETCH_ALIGN_FAULT_EN
        check("fault_set", {31'b0, fault}, 32'h1);
        check("fault_read_low", {31'b0, read}, 32'h0);
        a0 = acc_cnt;
        repeat (8) step();
        check("fault_no_issue", 32'(acc_cnt - a0), 32'd0);
        check("fault_no_valid", {31'b0, ins_valid}, 32'h0);
        check("fault_held", {31'b0, fault}, 32'h1);
        pulse_redirect(32'h200);
        check("fault_cleared", {31'b0, fault}, 32'h0);
        next_deliv("fault_resume", pc, word, dc);
        check("fault_resume_pc", pc, 32'h200);
`else
        check("fault_tied", {31'b0, fault}, 32'h0);
        next_deliv("align_force", pc, word, dc);
        check("align_force_pc", pc, 32'h100);
        check("align_force_word", word, 32'h100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
